// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 timing constants, totals and RGB565 colours for the display path
package vga_pkg;

  localparam logic [9:0] VGA_H_SYNC  = 10'd96;
  localparam logic [9:0] VGA_H_BACK  = 10'd48;
  localparam logic [9:0] VGA_H_VALID = 10'd640;
  localparam logic [9:0] VGA_H_FRONT = 10'd16;
  localparam logic [9:0] VGA_V_SYNC  = 10'd2;
  localparam logic [9:0] VGA_V_BACK  = 10'd33;
  localparam logic [9:0] VGA_V_VALID = 10'd480;
  localparam logic [9:0] VGA_V_FRONT = 10'd10;

  localparam int VGA_H_TOTAL = int'(VGA_H_SYNC) + int'(VGA_H_BACK) + int'(VGA_H_VALID) + int'(VGA_H_FRONT);
  localparam int VGA_V_TOTAL = int'(VGA_V_SYNC) + int'(VGA_V_BACK) + int'(VGA_V_VALID) + int'(VGA_V_FRONT);

  localparam logic [15:0] RGB565_BLACK = 16'h0000;
  localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB565_RED   = 16'hF800;
  localparam logic [15:0] RGB565_GREEN = 16'h07E0;
  localparam logic [15:0] RGB565_BLUE  = 16'h001F;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } vga_pos_t;

  // Last count value of an axis with the given total length.
  function automatic logic [9:0] axis_last(input int total);
    return 10'(total - 1);
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// rtl/vga_axis_cnt.sv - wrapping 10-bit position counter with enable and terminal count
module vga_axis_cnt #(
  parameter logic [9:0] LAST = 10'd799
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic       en,
  output logic [9:0] cnt,
  output logic       tc
);

  // tc marks the enabled cycle in which the counter wraps back to zero.
  assign tc = en && (cnt == LAST);

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= 10'd0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? 10'd0 : cnt + 10'd1;
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA raster timing generator with one-cycle-early pixel requests
// Optional VGA_TIMING_FRAME_CNT_EN adds an 8-bit completed-frame counter output frame_cnt.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter logic [9:0] H_SYNC   = VGA_H_SYNC,
  parameter logic [9:0] H_BACK   = VGA_H_BACK,
  parameter logic [9:0] H_VALID  = VGA_H_VALID,
  parameter logic [9:0] H_FRONT  = VGA_H_FRONT,
  parameter logic [9:0] V_SYNC   = VGA_V_SYNC,
  parameter logic [9:0] V_BACK   = VGA_V_BACK,
  parameter logic [9:0] V_VALID  = VGA_V_VALID,
  parameter logic [9:0] V_FRONT  = VGA_V_FRONT,
  parameter logic       SYNC_POL = 1'b1
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] rgb,
  output logic        rgb_valid,
  output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [7:0]  frame_cnt
`endif
);

  localparam int H_TOTAL = int'(H_SYNC) + int'(H_BACK) + int'(H_VALID) + int'(H_FRONT);
  localparam int V_TOTAL = int'(V_SYNC) + int'(V_BACK) + int'(V_VALID) + int'(V_FRONT);

  localparam logic [9:0] HA_START = H_SYNC + H_BACK;
  localparam logic [9:0] HA_END   = HA_START + H_VALID;
  localparam logic [9:0] HR_START = HA_START - 10'd1;
  localparam logic [9:0] HR_END   = HA_END - 10'd1;
  localparam logic [9:0] VA_START = V_SYNC + V_BACK;
  localparam logic [9:0] VA_END   = VA_START + V_VALID;

  if (H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_totals_too_large
    $error("vga_timing_ctrl: H_TOTAL and V_TOTAL must not exceed 1023");
  end

  logic [9:0] cnt_h;
  logic [9:0] cnt_v;
  logic       h_tc;
  logic       v_tc;

  vga_axis_cnt #(.LAST(axis_last(H_TOTAL))) u_cnt_h (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .en        (1'b1),
    .cnt       (cnt_h),
    .tc        (h_tc)
  );

  vga_axis_cnt #(.LAST(axis_last(V_TOTAL))) u_cnt_v (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .en        (h_tc),
    .cnt       (cnt_v),
    .tc        (v_tc)
  );

  logic     h_act;
  logic     h_req;
  logic     v_act;
  logic     pix_req;
  vga_pos_t req_pos;

  assign hsync = (cnt_h < H_SYNC) ? SYNC_POL : ~SYNC_POL;
  assign vsync = (cnt_v < V_SYNC) ? SYNC_POL : ~SYNC_POL;

  assign h_act = (cnt_h >= HA_START) && (cnt_h < HA_END);
  assign v_act = (cnt_v >= VA_START) && (cnt_v < VA_END);

  // The pattern generator registers its colour, so request one clock ahead of display.
  assign h_req   = (cnt_h >= HR_START) && (cnt_h < HR_END);
  assign pix_req = h_req && v_act;

  assign req_pos.x = pix_req ? (cnt_h - HR_START) : 10'h3FF;
  assign req_pos.y = pix_req ? (cnt_v - VA_START) : 10'h3FF;
  assign pix_x     = req_pos.x;
  assign pix_y     = req_pos.y;

  assign rgb_valid = h_act && v_act;
  assign rgb       = rgb_valid ? pix_data : RGB565_BLACK;

  // Vertical terminal count is the last clock of the frame, so this lands on (0,0).
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= v_tc;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_cnt <= 8'd0;
    end else if (v_tc) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Raster timing generator for the 640x480@60 Hz VGA output path, clocked at 25.2 MHz by vga_clk. Maintains horizontal/vertical position counters, drives hsync/vsync, and issues pixel coordinates one cycle early to the downstream pattern generator. That generator registers its pixel colour, so the returned pix_data lines up with the active-video window. Active-area pixels are gated onto rgb; all blanking pixels are forced to black.

## Interface
- H_SYNC, 10'd96, hsync pulse width (clocks)
- H_BACK, 10'd48, horizontal back porch
- H_VALID, 10'd640, active pixels per line
- H_FRONT, 10'd16, horizontal front porch
- V_SYNC, 10'd2, vsync pulse width (lines)
- V_BACK, 10'd33, vertical back porch
- V_VALID, 10'd480, active lines per frame
- V_FRONT, 10'd10, vertical front porch
- SYNC_POL, 1'b1, asserted level of hsync/vsync
- vga_clk  in  1  pixel clock; all logic on rising edge
- sys_rst_n  in  1  reset, asynchronous, active-low
- pix_data  in  16  RGB565 pixel returned for the previous cycle's pix_x/pix_y
- pix_x  out  10  requested column 0..H_VALID-1, 10'h3FF when no request
- pix_y  out  10  requested row 0..V_VALID-1, 10'h3FF when no request
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- rgb  out  16  RGB565 to DAC; 16'h0000 outside the active area
- rgb_valid  out  1  high in active-area cycles
- frame_start  out  1  one-cycle pulse at the first clock of each new frame

## Operation
- H_TOTAL = H_SYNC+H_BACK+H_VALID+H_FRONT (800). V_TOTAL = V_SYNC+V_BACK+V_VALID+V_FRONT (525).
- cnt_h (10 b) counts 0..H_TOTAL-1 and wraps to 0.
- cnt_v (10 b) increments only when cnt_h == H_TOTAL-1. It wraps to 0 when it is at V_TOTAL-1 at that same point.
- hsync = SYNC_POL while cnt_h < H_SYNC, otherwise ~SYNC_POL. vsync uses the same rule on cnt_v/V_SYNC.
- rgb_valid is high when H_SYNC+H_BACK <= cnt_h < H_SYNC+H_BACK+H_VALID and V_SYNC+V_BACK <= cnt_v < V_SYNC+V_BACK+V_VALID.
- pix_req uses the same window shifted one clock earlier horizontally: H_SYNC+H_BACK-1 <= cnt_h < H_SYNC+H_BACK+H_VALID-1, with the same vertical window.
- pix_x = cnt_h-(H_SYNC+H_BACK-1) and pix_y = cnt_v-(V_SYNC+V_BACK) when pix_req is high; both are 10'h3FF otherwise.
- rgb = rgb_valid ? pix_data : 16'h0000.
- frame_start is a register loaded with (cnt_h==H_TOTAL-1 && cnt_v==V_TOTAL-1). It is high exactly in the cycle where the counters read (0,0) after a wrap.
- All arithmetic is unsigned 10-bit. Parameters must keep H_TOTAL and V_TOTAL <= 1023; this is checked with an elaboration-time assertion.

## Timing
- Reset values: cnt_h=0, cnt_v=0, frame_start=0, hsync=vsync=SYNC_POL, rgb_valid=0, pix_x=pix_y=10'h3FF, rgb=0.
- Reset is asynchronous assertion with synchronous release. Mid-frame reset returns the counters to (0,0) immediately. No frame_start is emitted on reset release; the first pulse comes one full frame (H_TOTAL*V_TOTAL clocks) later.
- Request-to-data latency is one clock. pix_x=0 is presented at cnt_h=143, and the matching pix_data is sampled onto rgb at cnt_h=144.
- hsync, vsync, rgb_valid, pix_x and pix_y are combinational decodes of the registered counters. rgb is combinational from pix_data.
- At the line wrap (cnt_h 799->0), cnt_v advances in the same edge. At the frame wrap (799,524)->(0,0), frame_start rises on that edge.

## Configuration
- VGA_TIMING_FRAME_CNT_EN defined: adds output frame_cnt [7:0].
  - Reset value 0.
  - Increments on the same edge that raises frame_start, so it counts completed frames.
  - Wraps 255->0.
- Undefined: the port and its register are absent. All other behaviour is identical.

## Structure
- The shared package vga_pkg holds the 640x480 timing constants and the H_TOTAL/V_TOTAL derivations, plus the RGB565 colour constants used across the display path.
- One sub-module, vga_axis_cnt: a parameterised wrapping counter with an enable input and a terminal-count output.
  - Instantiated twice: horizontal with enable=1, vertical with enable = horizontal terminal count.

## Test plan
- Reset then run 800 clocks: hsync equals SYNC_POL for cnt_h 0..95 and is deasserted for 96..799; cnt_v is 1 at clock 800.
- Vertical timing: vsync is asserted for lines 0..1 only. rgb_valid first rises at (cnt_h=144, cnt_v=35) and is last high at (783, 514).
- Latency: drive pix_data = {6'b0, pix_x} delayed one clock from a bench model. rgb equals the column index 0..639 across the active line, and is 0 at cnt_h=143 and at 784.
- Blanking: hold pix_data=16'hFFFF; rgb=0 whenever rgb_valid=0, including all of line 34 and line 515.
- Frame wrap: frame_start pulses once per 420000 clocks, never on reset release. With VGA_TIMING_FRAME_CNT_EN, frame_cnt reads 1 after the first pulse and wraps 255->0.
- Mid-frame reset at (400,200): outputs return to their reset values asynchronously, counting restarts at (0,0), and the next frame_start arrives 420000 clocks after release.
